// File: rtl/cceip_kernel_pkg.sv
// Shared definitions for the CCEIP kernel: frame FSM encoding and keep-lane popcount.
package cceip_kernel_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RUN   = 4'd1,
    ST_DRAIN = 4'd2,
    ST_DONE  = 4'd3
  } state_e;

  // Widest keep vector supported (1024-bit stream); count of 128 fits in 8 bits.
  localparam int KEEP_MAX = 128;
  localparam int POPCNT_W = 8;

  function automatic logic [POPCNT_W-1:0] popcount(input logic [KEEP_MAX-1:0] v);
    logic [POPCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      c = c + {{(POPCNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cceip_sync_fifo.sv
// Single-clock FIFO with registered storage; DEPTH must be a power of two.
module cceip_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             ap_clk,
  input  logic             areset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/cceip_out_size_tracker.sv
// Counts bytes forwarded from the engine output stream to the write master and
// stops forwarding once the frame would exceed the latched buffer capacity.
module cceip_out_size_tracker
  import cceip_kernel_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int SIZE_WIDTH = 64
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [SIZE_WIDTH-1:0]   max_bytes,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [SIZE_WIDTH-1:0]   byte_count,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  state_e                  state_q;
  logic [SIZE_WIDTH-1:0]   byte_count_q;
  logic [SIZE_WIDTH-1:0]   byte_count_d;
  logic [SIZE_WIDTH-1:0]   max_bytes_q;
  logic                    overflow_q;
  logic                    done_q;
  logic                    busy_q;

  logic [KEEP_MAX-1:0]     keep_ext_s;
  logic [POPCNT_W-1:0]     beat_bytes_s;
  logic [SIZE_WIDTH:0]     sum_s;
  logic                    accept_s;
  logic                    fits_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic [DATA_WIDTH:0]     fifo_dout_s;

  // Beat qualification: a beat fits only if no earlier beat of the frame overflowed.
  always_comb begin
    keep_ext_s               = '0;
    keep_ext_s[KEEP_W-1:0]   = s_axis_tkeep;
    beat_bytes_s             = popcount(keep_ext_s);
    sum_s                    = {1'b0, byte_count_q} +
                               {{(SIZE_WIDTH+1-POPCNT_W){1'b0}}, beat_bytes_s};
    accept_s                 = (state_q == ST_RUN) && !fifo_full_s && s_axis_tvalid;
    fits_s                   = !overflow_q && (sum_s <= {1'b0, max_bytes_q});
    push_s                   = accept_s && fits_s;
    if (fits_s) begin
      byte_count_d = sum_s[SIZE_WIDTH-1:0];
    end else begin
      byte_count_d = byte_count_q;
    end
  end

  assign s_axis_tready = (state_q == ST_RUN) && !fifo_full_s;
  assign m_axis_tvalid = !fifo_empty_s;
  assign m_axis_tdata  = fifo_dout_s[DATA_WIDTH-1:0];
  // Storage is not reset, so tlast is masked while nothing is buffered.
  assign m_axis_tlast  = fifo_dout_s[DATA_WIDTH] && !fifo_empty_s;
  assign pop_s         = m_axis_tvalid && m_axis_tready;
  assign byte_count    = byte_count_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;

  cceip_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ap_clk  (ap_clk),
    .areset  (areset),
    .push_i  (push_s),
    .din_i   ({s_axis_tlast, s_axis_tdata}),
    .pop_i   (pop_s),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Frame FSM with byte counter, capacity latch and registered status flags.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      byte_count_q <= '0;
      max_bytes_q  <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            max_bytes_q  <= max_bytes;
            state_q      <= ST_RUN;
            busy_q       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            byte_count_q <= byte_count_d;
            if (!fits_s) begin
              overflow_q <= 1'b1;
            end
            if (s_axis_tlast) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty_s) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
